// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target register block.
package i2c_target_pkg;

  // Protocol FSM states
  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWrData,
    StWrAck,
    StRdData,
    StRdAck,
    StWait
  } state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned FILT_CYCLES = 3;
  localparam int unsigned FILT_CNT_W  = $clog2(FILT_CYCLES);

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchroniser, optional stability filter, and bus event detection.
// Optional feature macro: I2C_GLITCH_FILTER_EN adds a 3-cycle stability filter.
module i2c_line_sync
  import i2c_target_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic scl_raw,
  input  logic sda_raw,
  output logic scl,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic [1:0]             sync_s;       // {scl, sda} after synchroniser
  logic [1:0]             line_s;       // {scl, sda} after optional filter
  logic [1:0]             line_prev_q;

  // Synchroniser chains; an idle bus reads high
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_raw};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_raw};
    end
  end

  assign sync_s = {scl_sync_q[SYNC_STAGES-1], sda_sync_q[SYNC_STAGES-1]};

`ifdef I2C_GLITCH_FILTER_EN
  logic [1:0]            filt_q;
  logic [FILT_CNT_W-1:0] cnt_q [2];

  // Filtered value follows the input only after it has held for FILT_CYCLES cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q   <= '1;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_s[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == FILT_CNT_W'(FILT_CYCLES - 1)) begin
          filt_q[i] <= sync_s[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign line_s = filt_q;
`else
  assign line_s = sync_s;
`endif

  // One-cycle-delayed copy for edge and event detection
  always_ff @(posedge clk) begin
    if (rst) begin
      line_prev_q <= '1;
    end else begin
      line_prev_q <= line_s;
    end
  end

  assign scl       = line_s[1];
  assign sda       = line_s[0];
  assign scl_rise  = line_s[1] & ~line_prev_q[1];
  assign scl_fall  = ~line_s[1] & line_prev_q[1];
  // SDA edges only count as START/STOP while SCL is stable high
  assign start_det = line_s[1] & line_prev_q[1] & line_prev_q[0] & ~line_s[0];
  assign stop_det  = line_s[1] & line_prev_q[1] & ~line_prev_q[0] & line_s[0];

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with a byte-wide register file: pointer write, data write, data read.
// Optional feature macro: I2C_GLITCH_FILTER_EN (line glitch filter in i2c_line_sync).
module i2c_target_regs
  import i2c_target_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = 7'h3B,
  parameter int unsigned NUM_REGS = 16,
  localparam int unsigned PTR_W   = $clog2(NUM_REGS)
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_o,
  output logic             sda_t,
  input  logic [PTR_W-1:0] host_addr,
  output logic [7:0]       host_rdata,
  output logic             wr_stb,
  output logic [PTR_W-1:0] wr_idx,
  output logic [7:0]       wr_byte,
  output logic             busy
);

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync u_line_sync (
    .clk       (ap_clk),
    .rst       (ap_rst),
    .scl_raw   (scl_i),
    .sda_raw   (sda_i),
    .scl       (scl_s),
    .sda       (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_e           state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             rw_q, rw_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             sda_t_q, sda_t_d;
  logic             busy_q, busy_d;
  logic             rd_next_q, rd_next_d;
  logic             wr_stb_q, wr_stb_d;
  logic [PTR_W-1:0] wr_idx_q, wr_idx_d;
  logic [7:0]       wr_byte_q, wr_byte_d;
  logic             reg_we;
  logic [7:0]       regs_q [NUM_REGS];
  logic [7:0]       rx_byte;
  logic [7:0]       cur_byte;
  logic             drv_edge;

  assign rx_byte  = {shift_q[6:0], sda_s};
  assign cur_byte = regs_q[ptr_q];
  // SDA is only ever changed while SCL is low
  assign drv_edge = scl_fall & ~scl_s;

  // Next-state and datapath decisions
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rw_d      = rw_q;
    ptr_d     = ptr_q;
    sda_t_d   = sda_t_q;
    busy_d    = busy_q;
    rd_next_d = rd_next_q;
    wr_stb_d  = 1'b0;
    wr_idx_d  = wr_idx_q;
    wr_byte_d = wr_byte_q;
    reg_we    = 1'b0;

    if (stop_det) begin
      state_d   = StIdle;
      sda_t_d   = 1'b1;
      busy_d    = 1'b0;
      rd_next_d = 1'b0;
    end else if (start_det) begin
      // Repeated START keeps the pointer so pointer-write then read works
      state_d   = StAddr;
      bit_cnt_d = '0;
      sda_t_d   = 1'b1;
      rd_next_d = 1'b0;
    end else begin
      case (state_q)
        StIdle: ;
        StAddr: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (rx_byte[7:1] == DEV_ADDR) begin
                state_d = StAddrAck;
                rw_d    = rx_byte[0];
                busy_d  = 1'b1;
              end else begin
                state_d = StIdle;
                busy_d  = 1'b0;
              end
            end
          end
        end
        StPtr: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              ptr_d   = rx_byte[PTR_W-1:0];
              state_d = StPtrAck;
            end
          end
        end
        StWrData: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              reg_we    = 1'b1;
              wr_stb_d  = 1'b1;
              wr_idx_d  = ptr_q;
              wr_byte_d = rx_byte;
              ptr_d     = ptr_q + 1'b1;
              state_d   = StWrAck;
            end
          end
        end
        StAddrAck, StPtrAck, StWrAck: begin
          // First SCL fall starts the ACK, the second one ends it
          if (drv_edge) begin
            if (sda_t_q) begin
              sda_t_d = I2C_ACK;
            end else begin
              sda_t_d   = 1'b1;
              bit_cnt_d = '0;
              if (state_q != StAddrAck) begin
                state_d = StWrData;
              end else if (rw_q == RW_READ) begin
                state_d = StRdData;
                shift_d = cur_byte;
                sda_t_d = cur_byte[7];
              end else begin
                state_d = StPtr;
              end
            end
          end
        end
        StRdData: begin
          if (drv_edge) begin
            if (bit_cnt_q == 3'd7) begin
              sda_t_d = 1'b1;
              state_d = StRdAck;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
              shift_d   = {shift_q[6:0], 1'b0};
              sda_t_d   = shift_q[6];
            end
          end
        end
        StRdAck: begin
          if (scl_rise) begin
            if (sda_s == I2C_ACK) begin
              ptr_d     = ptr_q + 1'b1;
              rd_next_d = 1'b1;
            end else begin
              state_d = StWait;
            end
          end else if (drv_edge && rd_next_q) begin
            rd_next_d = 1'b0;
            bit_cnt_d = '0;
            shift_d   = cur_byte;
            sda_t_d   = cur_byte[7];
            state_d   = StRdData;
          end
        end
        StWait: ;
        default: state_d = StIdle;
      endcase
    end
  end

  // Protocol state registers
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      rw_q      <= RW_WRITE;
      ptr_q     <= '0;
      sda_t_q   <= 1'b1;
      busy_q    <= 1'b0;
      rd_next_q <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_idx_q  <= '0;
      wr_byte_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      rw_q      <= rw_d;
      ptr_q     <= ptr_d;
      sda_t_q   <= sda_t_d;
      busy_q    <= busy_d;
      rd_next_q <= rd_next_d;
      wr_stb_q  <= wr_stb_d;
      wr_idx_q  <= wr_idx_d;
      wr_byte_q <= wr_byte_d;
    end
  end

  // Register file, written only on a complete bus data byte
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (reg_we) begin
      regs_q[ptr_q] <= rx_byte;
    end
  end

  assign sda_o      = 1'b0;
  // Reset releases SDA immediately rather than waiting for the clock edge
  assign sda_t      = sda_t_q | ap_rst;
  assign busy       = busy_q;
  assign wr_stb     = wr_stb_q;
  assign wr_idx     = wr_idx_q;
  assign wr_byte    = wr_byte_q;
  assign host_rdata = regs_q[host_addr];

endmodule

// File: tb/tb_i2c_target_regs.sv
// Self-checking bench for i2c_target_regs: bit-banged I2C controller plus scoreboard.
module tb_i2c_target_regs;

  localparam int unsigned Q = 8;  // ap_clk cycles per quarter SCL period

  logic       ap_clk = 1'b0;
  logic       ap_rst = 1'b1;
  logic       tb_scl = 1'b1;
  logic       tb_sda = 1'b1;
  logic [3:0] host_addr = '0;
  logic       sda_o, sda_t, wr_stb, busy;
  logic [3:0] wr_idx;
  logic [7:0] wr_byte, host_rdata;
  logic       sda_line;

  // Open-drain wired-AND of controller and target
  assign sda_line = tb_sda & (sda_t | sda_o);

  i2c_target_regs #(
    .DEV_ADDR (7'h3B),
    .NUM_REGS (16)
  ) dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .scl_i      (tb_scl),
    .sda_i      (sda_line),
    .sda_o      (sda_o),
    .sda_t      (sda_t),
    .host_addr  (host_addr),
    .host_rdata (host_rdata),
    .wr_stb     (wr_stb),
    .wr_idx     (wr_idx),
    .wr_byte    (wr_byte),
    .busy       (busy)
  );

  always #5 ap_clk = ~ap_clk;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int wr_seen  = 0;

  logic [11:0] exp_wr [$];  // {idx, byte} per expected wr_stb
  logic [7:0]  exp_rd [$];  // bytes expected on bus reads
  logic [11:0] mon_exp;

  // Scoreboard side of register writes
  always @(negedge ap_clk) begin
    if (wr_stb === 1'b1) begin
      wr_seen++;
      if (exp_wr.size() == 0) begin
        fail_cnt++;
        $display("FAIL wr_stb_unexpected: got idx %0d byte %h, required no pulse", wr_idx, wr_byte);
      end else begin
        mon_exp = exp_wr.pop_front();
        if ({wr_idx, wr_byte} !== mon_exp) begin
          fail_cnt++;
          $display("FAIL wr_event: got idx %0d byte %h, required idx %0d byte %h",
                   wr_idx, wr_byte, mon_exp[11:8], mon_exp[7:0]);
        end else pass_cnt++;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_q();
    repeat (Q) @(negedge ap_clk);
  endtask

  task automatic bus_start();
    tb_sda = 1'b1; tb_scl = 1'b1; wait_q();
    tb_sda = 1'b0; wait_q();
    tb_scl = 1'b0; wait_q();
  endtask

  task automatic bus_rstart();
    tb_sda = 1'b1; wait_q();
    tb_scl = 1'b1; wait_q();
    tb_sda = 1'b0; wait_q();
    tb_scl = 1'b0; wait_q();
  endtask

  task automatic bus_stop();
    tb_sda = 1'b0; wait_q();
    tb_scl = 1'b1; wait_q();
    tb_sda = 1'b1; wait_q();
  endtask

  task automatic bus_bit(input logic b, output logic s);
    tb_sda = b;    wait_q();
    tb_scl = 1'b1; wait_q();
    s = sda_line;  wait_q();
    tb_scl = 1'b0; wait_q();
  endtask

  task automatic bus_wr(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
    bus_bit(1'b1, ack);
  endtask

  task automatic bus_rd(input logic ack_bit, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      d[i] = s;
    end
    bus_bit(ack_bit, s);
  endtask

  task automatic test_reset();
    repeat (4) @(negedge ap_clk);
    if (sda_t !== 1'b1) begin
      fail_cnt++; $display("FAIL rst_sda_t_during: got %b required 1", sda_t);
    end else pass_cnt++;
    ap_rst = 1'b0;
    repeat (4) @(negedge ap_clk);
    if ({sda_t, sda_o, busy, wr_stb} !== 4'b1000) begin
      fail_cnt++; $display("FAIL rst_ctrl: got {sda_t,sda_o,busy,wr_stb}=%b required 1000",
                           {sda_t, sda_o, busy, wr_stb});
    end else pass_cnt++;
    if ({wr_idx, wr_byte} !== 12'h000) begin
      fail_cnt++; $display("FAIL rst_wr_regs: got %h required 000", {wr_idx, wr_byte});
    end else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      host_addr = 4'(i); #1;
      if (host_rdata !== 8'h00) begin
        fail_cnt++; $display("FAIL rst_reg%0d: got %h required 00", i, host_rdata);
      end else pass_cnt++;
    end
  endtask

  task automatic test_write();
    logic ack;
    int   seen0;
    seen0 = wr_seen;
    bus_start();
    bus_wr(8'h76, ack);
    if (ack !== 1'b0) begin fail_cnt++; $display("FAIL wr_addr_ack: got %b required 0", ack); end
    else pass_cnt++;
    if (busy !== 1'b1) begin fail_cnt++; $display("FAIL wr_busy: got %b required 1", busy); end
    else pass_cnt++;
    bus_wr(8'h05, ack);
    if (ack !== 1'b0) begin fail_cnt++; $display("FAIL wr_ptr_ack: got %b required 0", ack); end
    else pass_cnt++;
    exp_wr.push_back({4'd5, 8'hA5});
    bus_wr(8'hA5, ack);
    if (ack !== 1'b0) begin fail_cnt++; $display("FAIL wr_d0_ack: got %b required 0", ack); end
    else pass_cnt++;
    exp_wr.push_back({4'd6, 8'h3C});
    bus_wr(8'h3C, ack);
    if (ack !== 1'b0) begin fail_cnt++; $display("FAIL wr_d1_ack: got %b required 0", ack); end
    else pass_cnt++;
    bus_stop();
    repeat (4) @(negedge ap_clk);
    if ({busy, sda_t} !== 2'b01) begin
      fail_cnt++; $display("FAIL wr_stop: got {busy,sda_t}=%b required 01", {busy, sda_t});
    end else pass_cnt++;
    if (wr_seen - seen0 !== 2) begin
      fail_cnt++; $display("FAIL wr_stb_count: got %0d required 2", wr_seen - seen0);
    end else pass_cnt++;
    host_addr = 4'd5; #1;
    if (host_rdata !== 8'hA5) begin fail_cnt++; $display("FAIL wr_reg5: got %h required a5", host_rdata); end
    else pass_cnt++;
    host_addr = 4'd6; #1;
    if (host_rdata !== 8'h3C) begin fail_cnt++; $display("FAIL wr_reg6: got %h required 3c", host_rdata); end
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic ack;
    bus_start();
    bus_wr(8'h76, ack);
    bus_wr(8'h0F, ack);
    exp_wr.push_back({4'd15, 8'h11});
    bus_wr(8'h11, ack);
    exp_wr.push_back({4'd0, 8'h22});
    bus_wr(8'h22, ack);
    if (ack !== 1'b0) begin fail_cnt++; $display("FAIL wrap_ack: got %b required 0", ack); end
    else pass_cnt++;
    bus_stop();
    host_addr = 4'd15; #1;
    if (host_rdata !== 8'h11) begin fail_cnt++; $display("FAIL wrap_reg15: got %h required 11", host_rdata); end
    else pass_cnt++;
    host_addr = 4'd0; #1;
    if (host_rdata !== 8'h22) begin fail_cnt++; $display("FAIL wrap_reg0: got %h required 22", host_rdata); end
    else pass_cnt++;
  endtask

  task automatic test_read();
    logic       ack, s;
    logic [7:0] d, e;
    exp_rd.push_back(8'hA5);
    exp_rd.push_back(8'h3C);
    bus_start();
    bus_wr(8'h76, ack);
    bus_wr(8'h05, ack);
    bus_rstart();
    bus_wr(8'h77, ack);
    if (ack !== 1'b0) begin fail_cnt++; $display("FAIL rd_addr_ack: got %b required 0", ack); end
    else pass_cnt++;
    bus_rd(1'b0, d);
    e = exp_rd.pop_front();
    if (d !== e) begin fail_cnt++; $display("FAIL rd_byte0: got %h required %h", d, e); end
    else pass_cnt++;
    bus_rd(1'b1, d);
    e = exp_rd.pop_front();
    if (d !== e) begin fail_cnt++; $display("FAIL rd_byte1: got %h required %h", d, e); end
    else pass_cnt++;
    if (sda_t !== 1'b1) begin fail_cnt++; $display("FAIL rd_nack_release: got %b required 1", sda_t); end
    else pass_cnt++;
    bus_bit(1'b1, s);
    if (s !== 1'b1) begin fail_cnt++; $display("FAIL rd_wait_line: got %b required 1", s); end
    else pass_cnt++;
    if (busy !== 1'b1) begin fail_cnt++; $display("FAIL rd_busy_wait: got %b required 1", busy); end
    else pass_cnt++;
    bus_stop();
    if (busy !== 1'b0) begin fail_cnt++; $display("FAIL rd_busy_stop: got %b required 0", busy); end
    else pass_cnt++;
  endtask

  task automatic test_nack_addr();
    logic ack;
    int   seen0;
    seen0 = wr_seen;
    bus_start();
    bus_wr(8'h78, ack);
    if (ack !== 1'b1) begin fail_cnt++; $display("FAIL nack_addr: got %b required 1", ack); end
    else pass_cnt++;
    if (busy !== 1'b0) begin fail_cnt++; $display("FAIL nack_busy: got %b required 0", busy); end
    else pass_cnt++;
    bus_wr(8'h05, ack);
    if (ack !== 1'b1) begin fail_cnt++; $display("FAIL nack_ignore0: got %b required 1", ack); end
    else pass_cnt++;
    bus_wr(8'h99, ack);
    if (ack !== 1'b1) begin fail_cnt++; $display("FAIL nack_ignore1: got %b required 1", ack); end
    else pass_cnt++;
    bus_stop();
    if (wr_seen != seen0) begin
      fail_cnt++; $display("FAIL nack_no_stb: got %0d pulses required 0", wr_seen - seen0);
    end else pass_cnt++;
    host_addr = 4'd5; #1;
    if (host_rdata !== 8'hA5) begin fail_cnt++; $display("FAIL nack_reg5: got %h required a5", host_rdata); end
    else pass_cnt++;
  endtask

  task automatic test_stop_partial();
    logic ack, s;
    logic [7:0] d;
    d = 8'h12;
    bus_start();
    bus_wr(8'h76, ack);
    bus_wr(8'h05, ack);
    for (int i = 7; i >= 4; i--) bus_bit(d[i], s);
    bus_stop();
    host_addr = 4'd5; #1;
    if (host_rdata !== 8'hA5) begin fail_cnt++; $display("FAIL partial_reg5: got %h required a5", host_rdata); end
    else pass_cnt++;
    if ({sda_t, busy} !== 2'b10) begin
      fail_cnt++; $display("FAIL partial_ctrl: got {sda_t,busy}=%b required 10", {sda_t, busy});
    end else pass_cnt++;
    // Idle target must ignore an address byte that has no START
    bus_wr(8'h76, ack);
    if (ack !== 1'b1) begin fail_cnt++; $display("FAIL partial_idle: got %b required 1", ack); end
    else pass_cnt++;
    bus_stop();
  endtask

  task automatic test_glitch();
`ifdef I2C_GLITCH_FILTER_EN
    logic       ack;
    logic [7:0] d;
    d = 8'hC3;
    bus_start();
    bus_wr(8'h76, ack);
    bus_wr(8'h07, ack);
    exp_wr.push_back({4'd7, 8'hC3});
    for (int i = 7; i >= 0; i--) begin
      tb_sda = d[i]; wait_q();
      tb_scl = 1'b1; wait_q();
      if (i == 4) begin
        tb_scl = 1'b0;
        repeat (2) @(negedge ap_clk);
        tb_scl = 1'b1;
      end
      wait_q();
      tb_scl = 1'b0; wait_q();
    end
    bus_bit(1'b1, ack);
    if (ack !== 1'b0) begin fail_cnt++; $display("FAIL glitch_ack: got %b required 0", ack); end
    else pass_cnt++;
    bus_stop();
    host_addr = 4'd7; #1;
    if (host_rdata !== 8'hC3) begin fail_cnt++; $display("FAIL glitch_reg7: got %h required c3", host_rdata); end
    else pass_cnt++;
`endif
  endtask

  task automatic test_reset_mid_ack();
    logic       s;
    logic [7:0] d;
    d = 8'h76;
    bus_start();
    for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
    for (int i = 0; i < 40 && sda_t !== 1'b0; i++) @(negedge ap_clk);
    if (sda_t !== 1'b0) begin fail_cnt++; $display("FAIL rmid_ack_drive: got %b required 0", sda_t); end
    else pass_cnt++;
    ap_rst = 1'b1; #1;
    if (sda_t !== 1'b1) begin fail_cnt++; $display("FAIL rmid_release: got %b required 1", sda_t); end
    else pass_cnt++;
    @(negedge ap_clk);
    if (sda_t !== 1'b1) begin fail_cnt++; $display("FAIL rmid_release_next: got %b required 1", sda_t); end
    else pass_cnt++;
    tb_scl = 1'b1;
    tb_sda = 1'b1;
    repeat (4) @(negedge ap_clk);
    ap_rst = 1'b0;
    repeat (8) @(negedge ap_clk);
    if ({sda_t, busy} !== 2'b10) begin
      fail_cnt++; $display("FAIL rmid_ctrl: got {sda_t,busy}=%b required 10", {sda_t, busy});
    end else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      host_addr = 4'(i); #1;
      if (host_rdata !== 8'h00) begin
        fail_cnt++; $display("FAIL rmid_reg%0d: got %h required 00", i, host_rdata);
      end else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_wrap();
    test_read();
    test_nack_addr();
    test_stop_partial();
    test_glitch();
    test_reset_mid_ack();
    if (exp_wr.size() != 0) begin
      fail_cnt++; $display("FAIL wr_scoreboard_left: got %0d pending required 0", exp_wr.size());
    end else pass_cnt++;
    if (exp_rd.size() != 0) begin
      fail_cnt++; $display("FAIL rd_scoreboard_left: got %0d pending required 0", exp_rd.size());
    end else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
    $finish;
  end

endmodule
